// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam int DEFAULT_ACK_TIMEOUT = 15;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master not granted last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last,
  output logic   valid,
  output owner_t owner
);

  always_comb begin
    valid = req0 | req1;
    owner = M0;
    if (req0 && req1) begin
      owner = (last == M0) ? M1 : M0;
    end else if (req1) begin
      owner = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single memory port: one-cycle issue, ack wait with
// timeout, and a registered response pulse to the owning master.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int CNT_WIDTH = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(ACK_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t                 state;
  owner_t                 owner;
  owner_t                 last;
  logic                   we;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   grant_valid;
  owner_t                 grant_owner;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  logic                   xfer_done;
  logic                   xfer_err;
  logic                   rdata_upd;
  logic [DATA_WIDTH-1:0]  rdata_val;

  rr_pick2 u_pick (
    .req0  (m0_req_i),
    .req1  (m1_req_i),
    .last  (last),
    .valid (grant_valid),
    .owner (grant_owner)
  );

  assign sel_we    = (grant_owner == M1) ? m1_we_i    : m0_we_i;
  assign sel_addr  = (grant_owner == M1) ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = (grant_owner == M1) ? m1_wdata_i : m0_wdata_i;

  // A real ack wins over a timeout landing on the same edge.
  assign xfer_done = mem_ack_i || (cnt == TIMEOUT_CNT);
  assign xfer_err  = !mem_ack_i;
  assign rdata_upd = xfer_err || !we;
  assign rdata_val = xfer_err ? '0 : mem_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= M0;
      last        <= M1;
      we          <= 1'b0;
      cnt         <= '0;
      m0_ack_o    <= 1'b0;
      m0_err_o    <= 1'b0;
      m0_rdata_o  <= '0;
      m1_ack_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      m1_rdata_o  <= '0;
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
    end else begin
      m0_ack_o    <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_ack_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner       <= grant_owner;
            we          <= sel_we;
            mem_addr_o  <= sel_addr;
            mem_data_o  <= sel_wdata;
            mem_rd_en_o <= !sel_we;
            mem_wr_en_o <= sel_we;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (xfer_done) begin
            state <= RESP;
            if (owner == M0) begin
              m0_ack_o <= 1'b1;
              m0_err_o <= xfer_err;
              if (rdata_upd) m0_rdata_o <= rdata_val;
            end else begin
              m1_ack_o <= 1'b1;
              m1_err_o <= xfer_err;
              if (rdata_upd) m1_rdata_o <= rdata_val;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        RESP: begin
          last  <= owner;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACK_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_ack_o    (m0_ack),
    .m0_err_o    (m0_err),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_ack_o    (m1_ack),
    .m1_err_o    (m1_err),
    .m1_rdata_o  (m1_rdata),
    .mem_rd_en_o (mem_rd_en),
    .mem_wr_en_o (mem_wr_en),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  // Bounded wait for the issue cycle; returns with the enable cycle sampled.
  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd_en || mem_wr_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin errors++; $display("FAIL reset_acks: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {mem_rd_en, mem_wr_en}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: addr %h data %h want 0", mem_addr, mem_wdata); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: %h %h want 0", m0_rdata, m1_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({mem_rd_en, mem_wr_en, m0_ack, m1_ack} !== 4'b0) begin errors++; $display("FAIL reset_idle: got %b want 0000", {mem_rd_en, mem_wr_en, m0_ack, m1_ack}); end
    $display("test_reset done");
  endtask

  task automatic test_m0_read;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk);
    checks++; if ({mem_rd_en, mem_wr_en} !== 2'b10) begin errors++; $display("FAIL read_en: got %b want 10", {mem_rd_en, mem_wr_en}); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h want 00000010", mem_addr); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL read_en_pulse: got %b want 0", mem_rd_en); end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL read_ack: m0_ack %b m0_err %b m1_ack %b want 1 0 0", m0_ack, m0_err, m1_ack); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", m0_rdata); end
    m0_req = 1'b0;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b want 0", m0_ack); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata_hold: got %h want deadbeef", m0_rdata); end
    $display("test_m0_read addr=10 rdata=%h", m0_rdata);
  endtask

  task automatic test_m1_write;
    bit rd_seen = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hCAFE0001;
    @(negedge clk);
    checks++; if ({mem_rd_en, mem_wr_en} !== 2'b01) begin errors++; $display("FAIL write_en: got %b want 01", {mem_rd_en, mem_wr_en}); end
    checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'hCAFE0001) begin errors++; $display("FAIL write_bus: addr %h data %h want 00000020 cafe0001", mem_addr, mem_wdata); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    rd_seen = rd_seen | mem_rd_en;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL write_en_pulse: got %b want 0", mem_wr_en); end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    rd_seen = rd_seen | mem_rd_en;
    checks++; if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL write_ack: m1_ack %b m1_err %b m0_ack %b want 1 0 0", m1_ack, m1_err, m0_ack); end
    checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_keep: got %h want 0", m1_rdata); end
    m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    checks++; if (rd_seen !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL write_rd_en_or_pulse: rd_seen %b m1_ack %b want 0 0", rd_seen, m1_ack); end
    $display("test_m1_write addr=20 data=cafe0001");
  endtask

  task automatic test_simultaneous;
    bit ok;
    logic [31:0] exp_addr;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 1) ? 32'h200 : 32'h100;
      wait_en(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_grant_timeout: xfer %0d no enable seen", k); end
      checks++; if (mem_addr !== exp_addr || mem_rd_en !== 1'b1) begin errors++; $display("FAIL rr_addr: xfer %0d addr %h rd_en %b want %h 1", k, mem_addr, mem_rd_en, exp_addr); end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h1000 + k;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = '0;
      checks++; if (m0_ack !== (k % 2 == 0) || m1_ack !== (k % 2 == 1)) begin errors++; $display("FAIL rr_ack: xfer %0d m0_ack %b m1_ack %b want m%0d", k, m0_ack, m1_ack, k % 2); end
      checks++; if (((k % 2 == 1) ? m1_rdata : m0_rdata) !== 32'h1000 + k) begin errors++; $display("FAIL rr_rdata: xfer %0d m0 %h m1 %h want %h", k, m0_rdata, m1_rdata, 32'h1000 + k); end
      $display("test_simultaneous xfer %0d granted m%0d addr=%h", k, k % 2, exp_addr);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    bit early = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
    wait_en(ok);
    checks++; if (!ok || mem_addr !== 32'h40) begin errors++; $display("FAIL timeout_grant: ok %b addr %h want 1 00000040", ok, mem_addr); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL timeout_early_ack: got 1 want 0"); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL timeout_ack: m0_ack %b m0_err %b m1_ack %b want 1 1 0", m0_ack, m0_err, m1_ack); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata: got %h want 0", m0_rdata); end
    m0_req = 1'b0;
    wait_en(ok);
    checks++; if (!ok || mem_addr !== 32'h44) begin errors++; $display("FAIL timeout_next_grant: ok %b addr %h want 1 00000044", ok, mem_addr); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5555;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'h5555) begin errors++; $display("FAIL timeout_next_ack: ack %b err %b rdata %h want 1 0 00005555", m1_ack, m1_err, m1_rdata); end
    m1_req = 1'b0;
    $display("test_timeout m0 err after 17 cycles, m1 served");
  endtask

  task automatic test_stray_ack;
    bit bad = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i < 2); mem_rdata = 32'hBADBAD00;
      @(negedge clk);
      if (m0_ack || m1_ack || mem_rd_en || mem_wr_en) bad = 1'b1;
    end
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stray_ack: activity seen %b want 0", bad); end
    checks++; if (m1_rdata !== 32'h5555) begin errors++; $display("FAIL stray_rdata: got %h want 00005555", m1_rdata); end
    $display("test_stray_ack idle stayed quiet");
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    bit m1_seen = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h80; m1_wdata = 32'h1234;
    wait_en(ok);
    checks++; if (!ok || mem_addr !== 32'h80) begin errors++; $display("FAIL rstwait_grant: ok %b addr %h want 1 00000080", ok, mem_addr); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    mem_ack = 1'b1;
    #1;
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err, mem_rd_en, mem_wr_en} !== 6'b0) begin errors++; $display("FAIL rstwait_flags: got %b want 000000", {m0_ack, m0_err, m1_ack, m1_err, mem_rd_en, mem_wr_en}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rstwait_data: addr %h wdata %h r0 %h r1 %h want 0", mem_addr, mem_wdata, m0_rdata, m1_rdata); end
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h90;
    @(negedge clk);
    m1_seen = m1_ack;
    checks++; if (m1_seen !== 1'b0) begin errors++; $display("FAIL rstwait_no_ack: got %b want 0", m1_seen); end
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h90) begin errors++; $display("FAIL rstwait_tie_m0: rd_en %b addr %h want 1 00000090", mem_rd_en, mem_addr); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hABCD;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'hABCD) begin errors++; $display("FAIL rstwait_m0_ack: m0_ack %b m1_ack %b rdata %h want 1 0 0000abcd", m0_ack, m1_ack, m0_rdata); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    $display("test_reset_in_wait tie after reset granted to m0");
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_simultaneous();
    test_timeout();
    test_stray_ack();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory arbiter that shares the single `Memory` port between the `Core` and a second requester, such as a boot loader, DMA, or debug port. It accepts one request at a time and grants round-robin on contention. It drives the memory enable, address, and data lines for exactly one cycle per transfer, then waits for the memory acknowledge. It returns read data, an ack pulse, and a timeout error to the granted master. It sits between the masters and `Memory` at the top level.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `ACK_TIMEOUT`, default 15: number of WAIT cycles without `mem_ack_i` before the transfer is aborted with an error. Must be ≥1.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `m0_req_i` / `m1_req_i`  in  1: request. Held high with stable attributes until ack.
- `m0_we_i` / `m1_we_i`  in  1: 1 = write, 0 = read.
- `m0_addr_i` / `m1_addr_i`  in  ADDR_WIDTH: address.
- `m0_wdata_i` / `m1_wdata_i`  in  DATA_WIDTH: write data.
- `m0_ack_o` / `m1_ack_o`  out  1: one-cycle completion pulse.
- `m0_err_o` / `m1_err_o`  out  1: timeout flag, valid with ack.
- `m0_rdata_o` / `m1_rdata_o`  out  DATA_WIDTH: read data, valid with ack, held until the next ack to that master.
- `mem_rd_en_o`  out  1: memory read enable.
- `mem_wr_en_o`  out  1: memory write enable.
- `mem_addr_o`  out  ADDR_WIDTH: memory address.
- `mem_data_o`  out  DATA_WIDTH: memory write data.
- `mem_data_i`  in  DATA_WIDTH: memory read data, valid with `mem_ack_i`.
- `mem_ack_i`  in  1: memory completion.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any request is high, select the owner and latch its `we`, `addr`, and `wdata`, then go to ISSUE.
  - With no request, stay in IDLE.
- **Selection:**
  - A single requester wins.
  - When both request, the master not granted last wins.
  - The `last` pointer resets to 1, so m0 wins the first tie.
- **ISSUE:**
  - For one cycle, assert `mem_rd_en_o` or `mem_wr_en_o` (never both) with the latched address and data.
  - Clear the timeout counter, then go to WAIT.
- **WAIT:**
  - All enables are low, and address and data are held.
  - If `mem_ack_i` is high, capture `mem_data_i` (for reads) and go to RESP with err = 0.
  - Otherwise increment the counter. When the counter reaches `ACK_TIMEOUT`, go to RESP with err = 1 and rdata = 0.
- **RESP:**
  - Pulse the owner's ack for one cycle, drive err, and update rdata.
  - For writes, rdata keeps its previous value.
  - Set `last` to the owner, then go to IDLE.
- `mem_ack_i` is ignored in IDLE, ISSUE, and RESP.
- If a master drops `req` mid-transfer, the transfer still completes and the ack is still pulsed.
- The non-owner's request is held pending. It is never dropped or acked.

## Timing
- **Reset (async assert, sync release):**
  - State goes to IDLE, and `last` to 1.
  - All acks, errs, and enables are 0.
  - All rdata, `mem_addr_o`, and `mem_data_o` are 0.
- All outputs are registered.
- **Latency:** request sampled at edge N → enable high in cycle N+1 → earliest `mem_ack_i` sampled at edge N+2 → ack high in cycle N+3.
- **Throughput:** minimum 4 cycles per transfer. The next request is sampled in the cycle after RESP.
- **Master handshake:** the master deasserts `req` on the edge after it sees ack, so IDLE does not re-grant the same request.
- **Timeout:** the ack with err is high exactly `ACK_TIMEOUT`+2 cycles after the enable cycle.
- **Reset mid-transfer:** the transfer is abandoned and no ack is issued.

## Structure
- Package `mem_arbiter_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - owner encoding (M0 = 0, M1 = 1);
  - the default `ACK_TIMEOUT` constant.
- Sub-module `rr_pick2`: combinational round-robin picker taking the two requests and `last`, and producing grant-valid and owner.
- The counter width is $clog2(`ACK_TIMEOUT`+1).

## Test plan
- **m0 read:** m0 reads addr 0x10 while memory returns 0xDEADBEEF with ack one cycle after `mem_rd_en_o`. Required: `mem_rd_en_o` high for 1 cycle with addr 0x10, then `m0_ack_o` is a 1-cycle pulse with rdata 0xDEADBEEF and err 0.
- **m1 write:** m1 writes 0xCAFE0001 to 0x20. Required: `mem_wr_en_o` high for 1 cycle with the correct address and data, `mem_rd_en_o` stays 0, and `m1_ack_o` pulses with err 0.
- **Simultaneous requests:** both masters hold requests continuously after reset. Required: grants alternate m0, m1, m0, m1, and each enable carries the matching address.
- **Ack timeout:** memory never acks and `ACK_TIMEOUT`=15. Required: the owner's ack and err are both 1 exactly 17 cycles after the enable, rdata is 0, and the FSM returns to IDLE and serves the other master.
- **Stray ack:** `mem_ack_i` is pulsed during IDLE. Required: no ack to either master.
- **Reset in WAIT:** `rst_n` drops during WAIT. Required: all outputs are 0 immediately and no ack is issued; after release, a tie is granted to m0.
